// File: rtl/cpu_step_controller_pkg.sv
// Shared types and constants for the CPU step controller.
// Imported by the interface, the debouncer and the top.
package cpu_step_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_e;

    localparam int DEBOUNCE_CNT_DEF = 16;
    localparam int SYNC_STAGES      = 2;

endpackage

// File: rtl/cpu_step_controller_if.sv
// Board-side signal bundle for the CPU step controller.
// master = controller, slave = board/core side.
interface cpu_step_controller_if #(
    parameter int CNT_W = 32
);

    logic             tick_in;
    logic             btn_step;
    logic             sw_run;
    logic             halt_in;
    logic             cpu_en;
    logic [CNT_W-1:0] step_count;
    logic [1:0]       state_out;

    modport master (
        input  tick_in,
        input  btn_step,
        input  sw_run,
        input  halt_in,
        output cpu_en,
        output step_count,
        output state_out
    );

    modport slave (
        output tick_in,
        output btn_step,
        output sw_run,
        output halt_in,
        input  cpu_en,
        input  step_count,
        input  state_out
    );

endinterface

// File: rtl/cpu_step_controller_btn_debounce.sv
// Step button synchronizer, debouncer and press-edge pulse.
// A new level is accepted after DEBOUNCE_CNT differing samples.
module cpu_step_controller_btn_debounce
    import cpu_step_controller_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
    input  logic clk_in,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = ($clog2(DEBOUNCE_CNT) > 0) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   level_prev_q;
    logic                   sample;

    assign sample = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sample != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sample;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], btn_i};
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
        end
    end

    // Releases (1->0) deliberately produce nothing.
    assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/cpu_step_controller.sv
// Turns divided-clock ticks and step presses into one-cycle core
// enables, with run/step/halt modes and a saturating step counter.
module cpu_step_controller
    import cpu_step_controller_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int CNT_W        = 32
) (
    input  logic                 clk_in,
    input  logic                 rst,
    cpu_step_controller_if.master bus
);

    logic [SYNC_STAGES-1:0] tick_sync_q;
    logic                   tick_prev_q;
    logic [SYNC_STAGES-1:0] run_sync_q;
    state_e                 state_q, state_d;
    logic                   cpu_en_q;
    logic [CNT_W-1:0]       step_count_q, step_count_d;
    logic                   tick_rise;
    logic                   run_s;
    logic                   press;
    logic                   grant;

    cpu_step_controller_btn_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_btn (
        .clk_in (clk_in),
        .rst    (rst),
        .btn_i  (bus.btn_step),
        .press_o(press)
    );

    assign tick_rise = tick_sync_q[SYNC_STAGES-1] & ~tick_prev_q;
    assign run_s     = run_sync_q[SYNC_STAGES-1];

    // halt_in outranks every other input in every state.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.halt_in)  state_d = ST_HALT;
                else if (run_s)   state_d = ST_RUN;
                else if (press)   state_d = ST_STEP;
            end
            ST_RUN: begin
                if (bus.halt_in)  state_d = ST_HALT;
                else if (!run_s)  state_d = ST_IDLE;
                else              grant   = tick_rise;
            end
            ST_STEP: begin
                if (bus.halt_in) begin
                    state_d = ST_HALT;
                end else if (tick_rise) begin
                    grant   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_comb begin
        step_count_d = step_count_q;
        if (grant && (step_count_q != {CNT_W{1'b1}})) begin
            step_count_d = step_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            tick_sync_q  <= '0;
            tick_prev_q  <= 1'b0;
            run_sync_q   <= '0;
            state_q      <= ST_IDLE;
            cpu_en_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            tick_sync_q  <= {tick_sync_q[SYNC_STAGES-2:0], bus.tick_in};
            tick_prev_q  <= tick_sync_q[SYNC_STAGES-1];
            run_sync_q   <= {run_sync_q[SYNC_STAGES-2:0], bus.sw_run};
            state_q      <= state_d;
            cpu_en_q     <= grant;
            step_count_q <= step_count_d;
        end
    end

    assign bus.cpu_en     = cpu_en_q;
    assign bus.step_count = step_count_q;
    assign bus.state_out  = state_q;

endmodule
